// File: rtl/tdc_hit_sequencer_pkg.sv
// Shared types and helpers for the TDC hit sequencer and its arbiter.
package tdc_hit_sequencer_pkg;

  localparam int COARSE_W_DEF = 16;

  // Index width for n items, never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_e;

endpackage

// File: rtl/tdc_hit_sequencer_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr, cyclically.
module tdc_rr_arbiter
  import tdc_hit_sequencer_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int CH_W = ch_w(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] gnt_idx,
  output logic            gnt_any
);

  // Scan all channels starting at ptr and keep the first requester found.
  always_comb begin
    int  k;
    logic found;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      k = (int'(ptr) + i) % NCH;
      if (!found && req[k]) begin
        found   = 1'b1;
        gnt_idx = CH_W'(k);
      end
    end
    gnt_any = |req;
  end

endmodule

// File: rtl/tdc_hit_sequencer.sv
// Multi-channel hit sequencer: timestamps filtered hits, applies dead time,
// and serialises events to the readout through a valid/ready port.
//
//   state    | meaning
//   ST_IDLE  | no event offered; grant as soon as any channel is pending
//   ST_OFFER | event held on evt_*; on handshake grant the next pending one
module tdc_hit_sequencer
  import tdc_hit_sequencer_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int COARSE_W = COARSE_W_DEF,
  parameter int DEAD_CYC = 4,
  localparam int CH_W    = ch_w(NCH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [NCH-1:0]      hit_valid,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [CH_W-1:0]     evt_ch,
  output logic [COARSE_W-1:0] evt_coarse,
  output logic                evt_lost,
  output logic                busy
);

  localparam int DEAD_W = ch_w(DEAD_CYC + 1);
  // The hit cycle itself is the first dead cycle, so the counter is loaded
  // with one less than the dead time.
  localparam logic [DEAD_W-1:0] DEAD_LOAD = (DEAD_CYC > 0) ? DEAD_W'(DEAD_CYC - 1) : '0;

  state_e              state_q, state_d;
  logic [COARSE_W-1:0] coarse_q, coarse_d;
  logic [NCH-1:0]      pend_q, pend_d, lost_q, lost_d;
  logic [COARSE_W-1:0] ts_q [NCH];
  logic [COARSE_W-1:0] ts_d [NCH];
  logic [DEAD_W-1:0]   dead_q [NCH];
  logic [DEAD_W-1:0]   dead_d [NCH];
  logic [CH_W-1:0]     rr_q, rr_d;
  logic [CH_W-1:0]     evt_ch_q, evt_ch_d;
  logic [COARSE_W-1:0] evt_coarse_q, evt_coarse_d;
  logic                evt_lost_q, evt_lost_d;

  logic [CH_W-1:0]     next_ch, arb_ptr, gnt_idx;
  logic                gnt_any, grant;
  logic [NCH-1:0]      hit_acc, granted;

  assign next_ch = (evt_ch_q == CH_W'(NCH - 1)) ? '0 : evt_ch_q + CH_W'(1);
  // In OFFER the pointer that would be written on handshake is used directly,
  // so back-to-back grants already respect the new rotation.
  assign arb_ptr = (state_q == ST_OFFER) ? next_ch : rr_q;

  tdc_rr_arbiter #(.NCH(NCH), .CH_W(CH_W)) u_arb (
    .req     (pend_q),
    .ptr     (arb_ptr),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // FSM next state, round-robin pointer and output register load.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    grant        = 1'b0;
    evt_ch_d     = evt_ch_q;
    evt_coarse_d = evt_coarse_q;
    evt_lost_d   = evt_lost_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          grant   = 1'b1;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (evt_ready) begin
          rr_d = next_ch;
          if (gnt_any) grant = 1'b1;
          else         state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (grant) begin
      evt_ch_d     = gnt_idx;
      evt_coarse_d = ts_q[gnt_idx];
      evt_lost_d   = lost_q[gnt_idx];
    end
  end

  // Per-channel hit qualification and grant decode.
  always_comb begin
    hit_acc = '0;
    granted = '0;
    for (int c = 0; c < NCH; c++) begin
      hit_acc[c] = en && hit_valid[c] && (dead_q[c] == '0);
      granted[c] = grant && (gnt_idx == CH_W'(c));
    end
  end

  // Per-channel pending/timestamp/loss/dead-time update and coarse counter.
  always_comb begin
    coarse_d = en ? coarse_q + COARSE_W'(1) : coarse_q;
    pend_d   = pend_q;
    lost_d   = lost_q;
    for (int c = 0; c < NCH; c++) begin
      ts_d[c]   = ts_q[c];
      dead_d[c] = (dead_q[c] != '0) ? dead_q[c] - DEAD_W'(1) : dead_q[c];
      if (granted[c]) begin
        pend_d[c] = 1'b0;
        lost_d[c] = 1'b0;
      end
      if (hit_acc[c]) begin
        if (!pend_q[c] || granted[c]) begin
          pend_d[c] = 1'b1;
          ts_d[c]   = coarse_q;
          dead_d[c] = DEAD_LOAD;
        end else begin
          lost_d[c] = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      coarse_q     <= '0;
      pend_q       <= '0;
      lost_q       <= '0;
      rr_q         <= '0;
      evt_ch_q     <= '0;
      evt_coarse_q <= '0;
      evt_lost_q   <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        ts_q[c]   <= '0;
        dead_q[c] <= '0;
      end
    end else begin
      state_q      <= state_d;
      coarse_q     <= coarse_d;
      pend_q       <= pend_d;
      lost_q       <= lost_d;
      rr_q         <= rr_d;
      evt_ch_q     <= evt_ch_d;
      evt_coarse_q <= evt_coarse_d;
      evt_lost_q   <= evt_lost_d;
      for (int c = 0; c < NCH; c++) begin
        ts_q[c]   <= ts_d[c];
        dead_q[c] <= dead_d[c];
      end
    end
  end

  assign evt_valid  = (state_q == ST_OFFER);
  assign evt_ch     = evt_ch_q;
  assign evt_coarse = evt_coarse_q;
  assign evt_lost   = evt_lost_q;
  assign busy       = (|pend_q) || (state_q == ST_OFFER);

endmodule

// File: tb/tb_tdc_hit_sequencer.sv
// Directed bench for tdc_hit_sequencer: a 16-bit instance for the main
// scenarios and a 4-bit coarse instance for wrap and enable behaviour.
module tb_tdc_hit_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, en, evt_ready;
  logic [3:0]  hit_valid;
  logic        evt_valid, evt_lost, busy;
  logic [1:0]  evt_ch;
  logic [15:0] evt_coarse;

  logic        en4, ready4;
  logic [3:0]  hit4;
  logic        valid4, lost4, busy4;
  logic [1:0]  ch4;
  logic [3:0]  coarse4;

  int errs = 0;
  int checks = 0;
  int exp_c = 0;
  int exp_c4 = 0;
  int frozen;

  always #5 clk = ~clk;

  tdc_hit_sequencer #(.NCH(4), .COARSE_W(16), .DEAD_CYC(4)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .hit_valid  (hit_valid),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_ch     (evt_ch),
    .evt_coarse (evt_coarse),
    .evt_lost   (evt_lost),
    .busy       (busy)
  );

  tdc_hit_sequencer #(.NCH(4), .COARSE_W(4), .DEAD_CYC(4)) u_dut_w4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en4),
    .hit_valid  (hit4),
    .evt_valid  (valid4),
    .evt_ready  (ready4),
    .evt_ch     (ch4),
    .evt_coarse (coarse4),
    .evt_lost   (lost4),
    .busy       (busy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs are applied at negedge and outputs sampled at negedge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      exp_c  = 0;
      exp_c4 = 0;
    end else begin
      if (en)  exp_c  = (exp_c + 1) % 65536;
      if (en4) exp_c4 = (exp_c4 + 1) % 16;
    end
    @(negedge clk);
  endtask

  task automatic hit(input logic [3:0] m);
    hit_valid = m;
    tick();
    hit_valid = 4'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hit_valid = (i % 2 == 0) ? 4'b1010 : 4'b0101;
      tick();
    end
    hit_valid = 4'b0;
  endtask

  task automatic wait_to(input int n);
    int g = 0;
    while (exp_c != n && g < 300) begin
      tick();
      g++;
    end
    chk("wait_coarse", exp_c, n);
  endtask

  task automatic wait_to4(input int n);
    int g = 0;
    while (exp_c4 != n && g < 40) begin
      tick();
      g++;
    end
    chk("wait_coarse4", exp_c4, n);
  endtask

  // Waits (bounded) for an event on the main instance, checks it, consumes it.
  task automatic wait_evt(input string tag, input int ch, input int co, input int lo);
    int g = 0;
    while (!evt_valid && g < 20) begin
      tick();
      g++;
    end
    chk({tag, "_valid"}, evt_valid, 1);
    chk({tag, "_ch"}, evt_ch, ch);
    chk({tag, "_coarse"}, evt_coarse, co);
    chk({tag, "_lost"}, evt_lost, lo);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; hit_valid = 4'b0; evt_ready = 1'b1;
    en4 = 1'b0; hit4 = 4'b0; ready4 = 1'b1;
    @(negedge clk);

    // 1: reset with toggling hits, then first hit right after release
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hit_valid = (i % 2 == 0) ? 4'b1111 : 4'b0110;
      tick();
      chk("rst_valid", evt_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_coarse", evt_coarse, 0);
    end
    rst_n = 1'b1;
    hit(4'b0001);
    wait_evt("t1_first", 0, 0, 0);

    // 4: output stalled by ch0, ch1 hits twice -> one ch1 event with lost
    evt_ready = 1'b0;
    wait_to(4);
    hit(4'b0001);
    hit(4'b0010);
    wait_to(12);
    hit(4'b0010);
    chk("t4_hold_valid", evt_valid, 1);
    chk("t4_hold_ch", evt_ch, 0);
    chk("t4_hold_coarse", evt_coarse, 4);
    chk("t4_busy", busy, 1);
    evt_ready = 1'b1;
    tick();
    wait_evt("t4_lost", 1, 5, 1);
    chk("t4_idle", evt_valid, 0);
    wait_to(16);
    hit(4'b0010);
    wait_evt("t4_next", 1, 16, 0);

    // 2: single hit with exact one-cycle grant latency
    do_reset();
    rst_n = 1'b1;
    wait_to(16);
    hit(4'b0100);
    chk("t2_lat0_valid", evt_valid, 0);
    chk("t2_lat0_busy", busy, 1);
    tick();
    chk("t2_lat1_valid", evt_valid, 1);
    wait_evt("t2", 2, 16, 0);
    chk("t2_done_valid", evt_valid, 0);
    chk("t2_done_busy", busy, 0);

    // 3: simultaneous bursts drain back-to-back in round-robin order
    do_reset();
    rst_n = 1'b1;
    for (int b = 0; b < 2; b++) begin
      wait_to(32 + 8 * b);
      hit(4'b1111);
      tick();
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("t3_b%0d_valid%0d", b, k), evt_valid, 1);
        chk($sformatf("t3_b%0d_ch%0d", b, k), evt_ch, k);
        chk($sformatf("t3_b%0d_coarse%0d", b, k), evt_coarse, 32 + 8 * b);
        chk($sformatf("t3_b%0d_lost%0d", b, k), evt_lost, 0);
        tick();
      end
      chk($sformatf("t3_b%0d_end", b), evt_valid, 0);
    end

    // 5: dead time swallows the hit at 102, accepts the one at 104
    wait_to(100);
    hit(4'b1000);
    tick();
    chk("t5_a_valid", evt_valid, 1);
    chk("t5_a_ch", evt_ch, 3);
    chk("t5_a_coarse", evt_coarse, 100);
    chk("t5_a_lost", evt_lost, 0);
    hit(4'b1000);
    chk("t5_dead_valid", evt_valid, 0);
    chk("t5_dead_busy", busy, 0);
    tick();
    hit(4'b1000);
    wait_evt("t5_b", 3, 104, 0);

    // 6: 4-bit coarse wrap, then en=0 ignores hits and freezes coarse
    do_reset();
    rst_n = 1'b1;
    en4 = 1'b1;
    wait_to4(15);
    hit4 = 4'b0010;
    tick();
    hit4 = 4'b0100;
    tick();
    hit4 = 4'b0000;
    chk("t6_a_valid", valid4, 1);
    chk("t6_a_ch", ch4, 1);
    chk("t6_a_coarse", coarse4, 15);
    chk("t6_a_lost", lost4, 0);
    tick();
    chk("t6_b_valid", valid4, 1);
    chk("t6_b_ch", ch4, 2);
    chk("t6_b_coarse", coarse4, 0);
    tick();
    chk("t6_b_end", valid4, 0);
    tick();
    en4 = 1'b0;
    frozen = exp_c4;
    hit4 = 4'b1000;
    tick();
    hit4 = 4'b0000;
    tick();
    tick();
    chk("t6_en0_valid", valid4, 0);
    chk("t6_en0_busy", busy4, 0);
    en4 = 1'b1;
    hit4 = 4'b1000;
    tick();
    hit4 = 4'b0000;
    tick();
    chk("t6_c_valid", valid4, 1);
    chk("t6_c_ch", ch4, 3);
    chk("t6_c_coarse", coarse4, frozen);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
